// File: rtl/dehaze_frame_ctrl_if.sv
// Bundles the dark-channel pixel stream, the software config port and the live
// parameter outputs of the dehaze frame controller.
interface dehaze_frame_ctrl_if;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [7:0]  per_img_Dark;
  logic        cfg_wr;
  logic [7:0]  cfg_w_mult_255;
  logic [7:0]  cfg_t_min;
  logic [7:0]  cfg_a_manual;
  logic        cfg_a_mode;
  logic [7:0]  atmospheric_light;
  logic [7:0]  W_MULT_255;
  logic [7:0]  T_MIN;
  logic        param_update;
  logic        param_valid;
  logic [15:0] frame_cnt;
  logic [7:0]  peak_dark;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Dark,
           cfg_wr, cfg_w_mult_255, cfg_t_min, cfg_a_manual, cfg_a_mode,
    input  atmospheric_light, W_MULT_255, T_MIN, param_update, param_valid,
           frame_cnt, peak_dark
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Dark,
           cfg_wr, cfg_w_mult_255, cfg_t_min, cfg_a_manual, cfg_a_mode,
    output atmospheric_light, W_MULT_255, T_MIN, param_update, param_valid,
           frame_cnt, peak_dark
  );
endinterface

// File: rtl/dehaze_frame_ctrl.sv
// Per-frame parameter controller for the dehaze transmission stage: estimates and
// smooths atmospheric light, and commits shadowed config only in vertical blanking.
//
//   state  | meaning
//   IDLE   | blanking, waiting for vsync rise
//   ACCUM  | frame active, tracking peak dark value and valid pixel count
//   UPDATE | frame ended, computing next A and latching peak_dark
//   COMMIT | loading A, W and T_MIN into the live outputs
module dehaze_frame_ctrl #(
  parameter logic [7:0]  A_INIT    = 8'd255,
  parameter logic [7:0]  W_INIT    = 8'd230,
  parameter logic [7:0]  TMIN_INIT = 8'd25,
  parameter logic [7:0]  A_MIN     = 8'd16,
  parameter int          SMOOTH_SH = 2,
  parameter logic [15:0] MIN_PIX   = 16'd64
) (
  input  logic              clk,
  input  logic              rst_n,
  dehaze_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, COMMIT} state_t;

  state_t      state;
  logic        vsync_q;
  logic        rise_pend;
  logic [7:0]  acc_max;
  logic [15:0] pix_cnt;
  logic [7:0]  a_next;
  logic [7:0]  pend_w;
  logic [7:0]  pend_t;
  logic [7:0]  pend_a;
  logic        pend_mode;

  logic              rise, fall, pix_ok;
  logic signed [9:0] diff, step, smooth, a_raw;

  assign rise   = bus.per_frame_vsync & ~vsync_q;
  assign fall   = ~bus.per_frame_vsync & vsync_q;
  assign pix_ok = bus.per_frame_clken & bus.per_frame_href;

  // Signed 10-bit so a falling peak shifts arithmetically toward the new value.
  assign diff   = $signed({2'b00, acc_max}) - $signed({2'b00, bus.atmospheric_light});
  assign step   = diff >>> SMOOTH_SH;
  assign smooth = $signed({2'b00, bus.atmospheric_light}) + step;

  always_comb begin
    a_raw = $signed({2'b00, bus.atmospheric_light});
    if (pend_mode)
      a_raw = $signed({2'b00, pend_a});
    else if (pix_cnt >= MIN_PIX)
      a_raw = bus.param_valid ? smooth : $signed({2'b00, acc_max});
  end

  function automatic logic [7:0] clamp_a(input logic signed [9:0] v);
    if (v < $signed({2'b00, A_MIN}))   return A_MIN;
    else if (v > $signed(10'sd255))    return 8'd255;
    else                               return v[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      vsync_q               <= 1'b0;
      rise_pend             <= 1'b0;
      acc_max               <= 8'd0;
      pix_cnt               <= 16'd0;
      a_next                <= A_INIT;
      pend_w                <= W_INIT;
      pend_t                <= TMIN_INIT;
      pend_a                <= A_INIT;
      pend_mode             <= 1'b0;
      bus.atmospheric_light <= A_INIT;
      bus.W_MULT_255        <= W_INIT;
      bus.T_MIN             <= TMIN_INIT;
      bus.param_update      <= 1'b0;
      bus.param_valid       <= 1'b0;
      bus.frame_cnt         <= 16'd0;
      bus.peak_dark         <= 8'd0;
    end else begin
      vsync_q          <= bus.per_frame_vsync;
      bus.param_update <= 1'b0;
      // Pending regs load in any state; COMMIT reads the pre-write values.
      if (bus.cfg_wr) begin
        pend_w    <= bus.cfg_w_mult_255;
        pend_t    <= bus.cfg_t_min;
        pend_a    <= bus.cfg_a_manual;
        pend_mode <= bus.cfg_a_mode;
      end
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= ACCUM;
            acc_max <= 8'd0;
            pix_cnt <= 16'd0;
          end
        end
        ACCUM: begin
          if (pix_ok) begin
            if (bus.per_img_Dark > acc_max) acc_max <= bus.per_img_Dark;
            if (pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
          end
          if (fall) state <= UPDATE;
        end
        UPDATE: begin
          bus.peak_dark    <= acc_max;
          a_next           <= clamp_a(a_raw);
          rise_pend        <= rise;
          bus.param_update <= 1'b1;
          state            <= COMMIT;
        end
        COMMIT: begin
          bus.atmospheric_light <= a_next;
          bus.W_MULT_255        <= pend_w;
          bus.T_MIN             <= pend_t;
          bus.param_valid       <= 1'b1;
          bus.frame_cnt         <= bus.frame_cnt + 16'd1;
          rise_pend             <= 1'b0;
          if (rise || rise_pend) begin
            state   <= ACCUM;
            acc_max <= 8'd0;
            pix_cnt <= 16'd0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// Randomized frame-level bench for dehaze_frame_ctrl, checked against a
// per-frame behavioural model of A estimation and config commit.
module tb_dehaze_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dehaze_frame_ctrl_if bus();

  dehaze_frame_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  always @(negedge clk) if (bus.param_update === 1'b1) pulses++;

  // Model: live outputs and pending config.
  logic [7:0]  m_a, m_w, m_t, m_peak;
  logic        m_valid;
  logic [15:0] m_fcnt;
  logic [7:0]  p_w, p_t, p_am;
  logic        p_mode;

  logic [7:0] pix_q[$];
  logic [7:0] nw, nt, na;
  logic       nm;

  function automatic logic [7:0] clamp(input int v);
    if (v < 16)  return 8'd16;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  task automatic model_reset();
    m_a = 8'd255; m_w = 8'd230; m_t = 8'd25; m_peak = 8'd0;
    m_valid = 1'b0; m_fcnt = 16'd0;
    p_w = 8'd230; p_t = 8'd25; p_am = 8'd255; p_mode = 1'b0;
  endtask

  task automatic model_commit(input int peak, input int cnt);
    int a;
    a = int'(m_a);
    if (p_mode)               a = int'(p_am);
    else if (cnt >= 64)       a = m_valid ? a + ((peak - a) >>> 2) : peak;
    m_a = clamp(a);
    m_w = p_w; m_t = p_t; m_peak = peak[7:0];
    m_valid = 1'b1; m_fcnt = m_fcnt + 16'd1;
  endtask

  task automatic build_q(input int n, input int peak);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(8'($urandom_range(0, peak)));
    if (n > 0) pix_q[$urandom_range(0, n - 1)] = peak[7:0];
  endtask

  task automatic cfg_write(input logic [7:0] w, input logic [7:0] t,
                           input logic [7:0] am, input logic mode);
    bus.cfg_w_mult_255 = w; bus.cfg_t_min = t;
    bus.cfg_a_manual = am;  bus.cfg_a_mode = mode;
    bus.cfg_wr = 1'b1;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
    p_w = w; p_t = t; p_am = am; p_mode = mode;
  endtask

  // Drives pix_q with random distractor cycles; caller has vsync high and sits at a negedge.
  task automatic feed(input bit mid_cfg, output int cnt, output int peak);
    cnt = 0; peak = 0;
    for (int i = 0; i < pix_q.size(); i++) begin
      if (mid_cfg && i == pix_q.size() / 2) begin
        bus.per_frame_clken = 1'b0;
        cfg_write(nw, nt, na, nm);
      end
      case ($urandom_range(0, 3))
        0: begin
          bus.per_frame_href = 1'b0; bus.per_frame_clken = 1'b1;
          bus.per_img_Dark = 8'd255; @(negedge clk);
        end
        1: begin
          bus.per_frame_href = 1'b1; bus.per_frame_clken = 1'b0;
          bus.per_img_Dark = 8'd255; @(negedge clk);
        end
        default: ;
      endcase
      bus.per_frame_href = 1'b1; bus.per_frame_clken = 1'b1;
      bus.per_img_Dark = pix_q[i];
      @(negedge clk);
      cnt++;
      if (int'(pix_q[i]) > peak) peak = int'(pix_q[i]);
    end
    bus.per_frame_href = 1'b0; bus.per_frame_clken = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // cfg_sel: 0 none, 1 write mid-frame, 2 write during the COMMIT cycle.
  task automatic run_frame(input string name, input int cfg_sel);
    int cnt, peak, p0;
    bit seen;
    @(negedge clk);
    bus.per_frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    feed(cfg_sel == 1, cnt, peak);
    #1;
    vectors++;
    if (bus.atmospheric_light !== m_a || bus.W_MULT_255 !== m_w || bus.T_MIN !== m_t) begin
      $display("FAIL %s live-stable-in-frame: A/W/T got %0d/%0d/%0d want %0d/%0d/%0d",
               name, bus.atmospheric_light, bus.W_MULT_255, bus.T_MIN, m_a, m_w, m_t);
      miscompares++;
    end
    @(negedge clk);
    bus.per_frame_vsync = 1'b0;
    p0 = pulses;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (bus.param_update === 1'b1) seen = 1'b1;
    end
    model_commit(peak, cnt);
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL %s commit-timeout: no param_update within 20 cycles", name);
    end else if (cfg_sel == 2) begin
      cfg_write(nw, nt, na, nm);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (pulses - p0 !== 1) begin
      $display("FAIL %s param_update-pulses: got %0d want 1", name, pulses - p0); miscompares++;
    end
    vectors++;
    if (bus.atmospheric_light !== m_a) begin
      $display("FAIL %s A: got %0d want %0d", name, bus.atmospheric_light, m_a); miscompares++;
    end
    vectors++;
    if (bus.W_MULT_255 !== m_w || bus.T_MIN !== m_t) begin
      $display("FAIL %s W/T: got %0d/%0d want %0d/%0d", name, bus.W_MULT_255, bus.T_MIN, m_w, m_t);
      miscompares++;
    end
    vectors++;
    if (bus.peak_dark !== m_peak) begin
      $display("FAIL %s peak_dark: got %0d want %0d", name, bus.peak_dark, m_peak); miscompares++;
    end
    vectors++;
    if (bus.frame_cnt !== m_fcnt || bus.param_valid !== m_valid) begin
      $display("FAIL %s frame_cnt/valid: got %0d/%0b want %0d/%0b",
               name, bus.frame_cnt, bus.param_valid, m_fcnt, m_valid);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.per_frame_vsync = 1'b0; bus.per_frame_href = 1'b0; bus.per_frame_clken = 1'b0;
    bus.per_img_Dark = 8'd0; bus.cfg_wr = 1'b0; bus.cfg_w_mult_255 = 8'd0;
    bus.cfg_t_min = 8'd0; bus.cfg_a_manual = 8'd0; bus.cfg_a_mode = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.atmospheric_light !== 8'd255 || bus.W_MULT_255 !== 8'd230 || bus.T_MIN !== 8'd25) begin
      $display("FAIL reset-live: A/W/T got %0d/%0d/%0d want 255/230/25",
               bus.atmospheric_light, bus.W_MULT_255, bus.T_MIN);
      miscompares++;
    end
    vectors++;
    if (bus.param_update !== 1'b0 || bus.param_valid !== 1'b0 ||
        bus.frame_cnt !== 16'd0 || bus.peak_dark !== 8'd0) begin
      $display("FAIL reset-status: upd/valid/fcnt/peak got %0b/%0b/%0d/%0d want 0/0/0/0",
               bus.param_update, bus.param_valid, bus.frame_cnt, bus.peak_dark);
      miscompares++;
    end
  endtask

  task automatic test_direct_load();
    pix_q.delete();
    for (int i = 0; i < 64; i++) pix_q.push_back(8'((i * 200) / 63));
    run_frame("direct_load", 0);
    vectors++;
    if (bus.atmospheric_light !== 8'd200) begin
      $display("FAIL direct_load-A200: got %0d want 200", bus.atmospheric_light); miscompares++;
    end
  endtask

  task automatic test_smoothing();
    build_q(64 + $urandom_range(0, 30), 40);
    run_frame("smooth_40", 0);
    vectors++;
    if (bus.atmospheric_light !== 8'd160) begin
      $display("FAIL smooth-A160: got %0d want 160", bus.atmospheric_light); miscompares++;
    end
    for (int f = 0; f < 12; f++) begin
      build_q(64, 0);
      run_frame("decay", 0);
    end
    vectors++;
    if (bus.atmospheric_light !== 8'd16) begin
      $display("FAIL decay-floor: got %0d want 16", bus.atmospheric_light); miscompares++;
    end
  endtask

  task automatic test_cfg_midframe();
    nw = 8'd200; nt = 8'd50; na = p_am; nm = 1'b0;
    build_q(80, $urandom_range(100, 255));
    run_frame("cfg_midframe", 1);
    vectors++;
    if (bus.W_MULT_255 !== 8'd200 || bus.T_MIN !== 8'd50) begin
      $display("FAIL cfg_midframe-applied: W/T got %0d/%0d want 200/50", bus.W_MULT_255, bus.T_MIN);
      miscompares++;
    end
  endtask

  task automatic test_cfg_commit();
    nw = 8'd77; nt = 8'd33; na = p_am; nm = 1'b0;
    build_q(70, $urandom_range(0, 255));
    run_frame("cfg_in_commit", 2);
    vectors++;
    if (bus.W_MULT_255 !== 8'd200 || bus.T_MIN !== 8'd50) begin
      $display("FAIL cfg_in_commit-deferred: W/T got %0d/%0d want 200/50", bus.W_MULT_255, bus.T_MIN);
      miscompares++;
    end
    build_q(70, $urandom_range(0, 255));
    run_frame("cfg_next_frame", 0);
    vectors++;
    if (bus.W_MULT_255 !== 8'd77 || bus.T_MIN !== 8'd33) begin
      $display("FAIL cfg_next_frame: W/T got %0d/%0d want 77/33", bus.W_MULT_255, bus.T_MIN);
      miscompares++;
    end
  endtask

  task automatic test_manual();
    @(negedge clk);
    cfg_write(p_w, p_t, 8'd5, 1'b1);
    build_q(100, 255);
    run_frame("manual_5", 0);
    vectors++;
    if (bus.atmospheric_light !== 8'd16) begin
      $display("FAIL manual-clamp: got %0d want 16", bus.atmospheric_light); miscompares++;
    end
    @(negedge clk);
    cfg_write(p_w, p_t, 8'd180, 1'b1);
    build_q($urandom_range(0, 100), $urandom_range(0, 255));
    run_frame("manual_180", 0);
    vectors++;
    if (bus.atmospheric_light !== 8'd180) begin
      $display("FAIL manual-180: got %0d want 180", bus.atmospheric_light); miscompares++;
    end
  endtask

  task automatic test_few_pixels();
    @(negedge clk);
    cfg_write(p_w, p_t, p_am, 1'b0);
    build_q(10, 250);
    run_frame("few_pixels", 0);
    vectors++;
    if (bus.atmospheric_light !== 8'd180) begin
      $display("FAIL few_pixels-A-held: got %0d want 180", bus.atmospheric_light); miscompares++;
    end
    pix_q.delete();
    run_frame("no_pixels", 0);
  endtask

  task automatic test_back_to_back();
    int cnt, peak, p0;
    @(negedge clk);
    bus.per_frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    build_q(90, $urandom_range(60, 255));
    feed(1'b0, cnt, peak);
    p0 = pulses;
    bus.per_frame_vsync = 1'b0;
    @(negedge clk);
    bus.per_frame_vsync = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    model_commit(peak, cnt);
    vectors++;
    if (pulses - p0 !== 1 || bus.atmospheric_light !== m_a || bus.frame_cnt !== m_fcnt) begin
      $display("FAIL b2b-first: pulses/A/fcnt got %0d/%0d/%0d want 1/%0d/%0d",
               pulses - p0, bus.atmospheric_light, bus.frame_cnt, m_a, m_fcnt);
      miscompares++;
    end
    build_q(90, $urandom_range(0, 255));
    feed(1'b0, cnt, peak);
    p0 = pulses;
    bus.per_frame_vsync = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    model_commit(peak, cnt);
    vectors++;
    if (pulses - p0 !== 1 || bus.atmospheric_light !== m_a || bus.peak_dark !== m_peak) begin
      $display("FAIL b2b-second: pulses/A/peak got %0d/%0d/%0d want 1/%0d/%0d",
               pulses - p0, bus.atmospheric_light, bus.peak_dark, m_a, m_peak);
      miscompares++;
    end
  endtask

  task automatic test_reset_midframe();
    int cnt, peak;
    @(negedge clk);
    bus.per_frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    build_q(30, 255);
    feed(1'b0, cnt, peak);
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (bus.atmospheric_light !== m_a || bus.W_MULT_255 !== m_w || bus.T_MIN !== m_t ||
        bus.param_valid !== 1'b0 || bus.frame_cnt !== 16'd0 || bus.peak_dark !== 8'd0 ||
        bus.param_update !== 1'b0) begin
      $display("FAIL reset_midframe: A/W/T/valid/fcnt/peak got %0d/%0d/%0d/%0b/%0d/%0d",
               bus.atmospheric_light, bus.W_MULT_255, bus.T_MIN, bus.param_valid,
               bus.frame_cnt, bus.peak_dark);
      miscompares++;
    end
    bus.per_frame_vsync = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    build_q(64, 90);
    run_frame("post_reset", 0);
    vectors++;
    if (bus.atmospheric_light !== 8'd90) begin
      $display("FAIL post_reset-A90: got %0d want 90", bus.atmospheric_light); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_direct_load();
    test_smoothing();
    test_cfg_midframe();
    test_cfg_commit();
    test_manual();
    test_few_pixels();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
